// File: rtl/kernel_loader_if.sv
// Bundles the configuration, weight-input and broadcast signals of kernel_loader.
// Handshake rule: a transfer occurs on a rising clk edge where valid and ready are both 1.
interface kernel_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [7:0]            cfg_kernel_size;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  flush_kernel;
  logic [7:0]            kernel_size;
  logic [DATA_WIDTH-1:0] fltr_data;
  logic                  fltr_valid;
  logic [NUM_COL-1:0]    kernel_busy;
  logic                  load_done;
  logic                  err_size;

  // The environment side: config source, weight FIFO and the multicaster column.
  modport master (
    output cfg_valid, cfg_kernel_size, w_valid, w_data, kernel_busy,
    input  cfg_ready, w_ready, flush_kernel, kernel_size, fltr_data, fltr_valid,
           load_done, err_size
  );

  modport slave (
    input  cfg_valid, cfg_kernel_size, w_valid, w_data, kernel_busy,
    output cfg_ready, w_ready, flush_kernel, kernel_size, fltr_data, fltr_valid,
           load_done, err_size
  );
endinterface

// File: rtl/kernel_loader.sv
// Buffers a whole filter kernel, then replays it as a gap-free broadcast burst
// to the multicaster column and waits for every weight buffer to go idle.
module kernel_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int MAX_KERNEL = 16
) (
  input  logic           clk,
  input  logic           rstn,
  kernel_loader_if.slave bus,
  output logic [2:0]     dbg_state
);
  localparam int IDX_W = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    FLUSH    = 3'd2,
    BURST    = 3'd3,
    WAIT_ACK = 3'd4
  } state_e;

  state_e                state, state_n;
  logic [7:0]            size_q, size_n;
  logic [IDX_W-1:0]      last_idx_q, last_idx_n;
  logic [IDX_W-1:0]      wr_cnt, wr_cnt_n;
  logic [IDX_W-1:0]      rd_cnt, rd_cnt_n;
  logic                  flush_q, flush_n;
  logic [7:0]            ksize_q, ksize_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  valid_q, valid_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic                  mem_we;
  logic                  size_ok;
  logic [NUM_COL-1:0]    busy;
  logic [DATA_WIDTH-1:0] mem [MAX_KERNEL];

  assign busy    = bus.kernel_busy;
  assign size_ok = (bus.cfg_kernel_size != 8'd0) &&
                   (int'(bus.cfg_kernel_size) <= MAX_KERNEL);

  // Ready signals depend on the state register alone.
  assign bus.cfg_ready    = (state == IDLE);
  assign bus.w_ready      = (state == COLLECT);
  assign bus.flush_kernel = flush_q;
  assign bus.kernel_size  = ksize_q;
  assign bus.fltr_data    = data_q;
  assign bus.fltr_valid   = valid_q;
  assign bus.load_done    = done_q;
  assign bus.err_size     = err_q;
  assign dbg_state        = state;

  always_comb begin
    state_n    = state;
    size_n     = size_q;
    last_idx_n = last_idx_q;
    wr_cnt_n   = wr_cnt;
    rd_cnt_n   = rd_cnt;
    flush_n    = 1'b0;
    ksize_n    = ksize_q;
    data_n     = data_q;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (size_ok) begin
            size_n     = bus.cfg_kernel_size;
            last_idx_n = IDX_W'(bus.cfg_kernel_size - 8'd1);
            wr_cnt_n   = '0;
            state_n    = COLLECT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.w_valid) begin
          mem_we   = 1'b1;
          wr_cnt_n = wr_cnt + IDX_W'(1);
          if (wr_cnt == last_idx_q) begin
            flush_n = 1'b1;
            ksize_n = size_q;
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Output registers run one word ahead of rd_cnt so word 0 follows the flush directly.
        rd_cnt_n = '0;
        data_n   = mem[0];
        valid_n  = 1'b1;
        state_n  = BURST;
      end
      BURST: begin
        if (rd_cnt == last_idx_q) begin
          state_n = WAIT_ACK;
        end else begin
          rd_cnt_n = rd_cnt + IDX_W'(1);
          data_n   = mem[rd_cnt + IDX_W'(1)];
          valid_n  = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (!(|busy)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      size_q     <= '0;
      last_idx_q <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      flush_q    <= 1'b0;
      ksize_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      size_q     <= size_n;
      last_idx_q <= last_idx_n;
      wr_cnt     <= wr_cnt_n;
      rd_cnt     <= rd_cnt_n;
      flush_q    <= flush_n;
      ksize_q    <= ksize_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  // Kernel storage carries no reset; a reset always restarts from a fresh collect.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_cnt] <= bus.w_data;
  end
endmodule

// File: tb/tb_kernel_loader.sv
// Directed bench for kernel_loader: drives configs and weights at the falling edge
// and checks handshakes, burst timing and burst contents against hand-built expectations.
module tb_kernel_loader;
  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] dbg_state;

  kernel_loader_if #(.DATA_WIDTH(16), .NUM_COL(4)) bus ();

  kernel_loader #(.DATA_WIDTH(16), .NUM_COL(4), .MAX_KERNEL(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  cur_ksize = 8'd0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every broadcast word must match the next expected weight.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.fltr_valid === 1'b1) begin
      if (exp_q.size() == 0) check("extra_word", 32'(bus.fltr_valid), 32'd0);
      else check("fltr_data", 32'(bus.fltr_data), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic send_cfg(input logic [7:0] sz, input bit keep);
    bus.cfg_valid       = 1'b1;
    bus.cfg_kernel_size = sz;
    @(negedge clk);
    check("cfg_accept", 32'(bus.w_ready), 32'd1);
    check("cfg_ready_busy", 32'(bus.cfg_ready), 32'd0);
    if (!keep) bus.cfg_valid = 1'b0;
  endtask

  task automatic bad_cfg(input logic [7:0] sz);
    bus.cfg_valid       = 1'b1;
    bus.cfg_kernel_size = sz;
    @(negedge clk);
    check("err_pulse", 32'(bus.err_size), 32'd1);
    check("err_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("err_no_flush", 32'(bus.flush_kernel), 32'd0);
    check("err_ksize", 32'(bus.kernel_size), 32'(cur_ksize));
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("err_one_cycle", 32'(bus.err_size), 32'd0);
    check("err_idle", 32'(bus.cfg_ready), 32'd1);
  endtask

  // Streams sz weights (base+i) under w_valid pattern vpat, then follows the burst
  // and the busy wait. Starts on the falling edge right after the config accept.
  task automatic load_body(input int sz, input logic [15:0] base, input logic [31:0] vpat,
                           input int plen, input bit extra, input logic [3:0] busy,
                           input int hold, input bit cfg_in_burst, input logic [7:0] next_sz,
                           input int abort_at);
    int idx  = 0;
    int step = 0;
    bit v;
    while (idx < sz && step < 200) begin
      v           = (plen == 0) ? 1'b1 : vpat[step % plen];
      bus.w_valid = v;
      bus.w_data  = base + 16'(idx);
      @(negedge clk);
      if (v) begin
        exp_q.push_back(base + 16'(idx));
        idx++;
      end
      step++;
      if (idx < sz) begin
        check("collect_w_ready", 32'(bus.w_ready), 32'd1);
        check("collect_no_flush", 32'(bus.flush_kernel), 32'd0);
        check("ksize_hold", 32'(bus.kernel_size), 32'(cur_ksize));
      end
    end
    check("collect_done", 32'(idx), 32'(sz));
    check("flush_pulse", 32'(bus.flush_kernel), 32'd1);
    check("flush_ksize", 32'(bus.kernel_size), 32'(sz));
    check("flush_w_ready", 32'(bus.w_ready), 32'd0);
    check("flush_no_valid", 32'(bus.fltr_valid), 32'd0);
    cur_ksize       = 8'(sz);
    bus.w_valid     = extra;
    bus.w_data      = 16'hDEAD;
    bus.kernel_busy = busy;
    for (int k = 0; k < sz; k++) begin
      if (cfg_in_burst) begin
        bus.cfg_valid       = 1'b1;
        bus.cfg_kernel_size = 8'd2;
      end
      @(negedge clk);
      check("burst_valid", 32'(bus.fltr_valid), 32'd1);
      check("burst_no_flush", 32'(bus.flush_kernel), 32'd0);
      check("burst_w_ready", 32'(bus.w_ready), 32'd0);
      check("burst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      if (k == abort_at) begin
        #2 rstn = 1'b0;
        #1;
        check("rst_flush", 32'(bus.flush_kernel), 32'd0);
        check("rst_valid", 32'(bus.fltr_valid), 32'd0);
        check("rst_data", 32'(bus.fltr_data), 32'd0);
        check("rst_ksize", 32'(bus.kernel_size), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);
        check("rst_err", 32'(bus.err_size), 32'd0);
        check("rst_w_ready", 32'(bus.w_ready), 32'd0);
        exp_q.delete();
        cur_ksize       = 8'd0;
        bus.w_valid     = 1'b0;
        bus.kernel_busy = 4'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        return;
      end
    end
    if (cfg_in_burst) bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("burst_end_valid", 32'(bus.fltr_valid), 32'd0);
    check("burst_hold_data", 32'(bus.fltr_data), 32'(base + 16'(sz - 1)));
    check("wait_no_done", 32'(bus.load_done), 32'd0);
    check("wait_state", 32'(dbg_state), 32'd4);
    if (hold <= 1) bus.kernel_busy = 4'b0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("wait_busy", 32'(bus.load_done), 32'd0);
      if (i == hold - 1) bus.kernel_busy = 4'b0;
    end
    if (next_sz != 8'd0) bus.cfg_kernel_size = next_sz;
    @(negedge clk);
    check("load_done", 32'(bus.load_done), 32'd1);
    check("done_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("done_no_err", 32'(bus.err_size), 32'd0);
    bus.w_valid = 1'b0;
    if (next_sz != 8'd0) return;
    @(negedge clk);
    check("done_one_cycle", 32'(bus.load_done), 32'd0);
    check("idle_cfg_ready", 32'(bus.cfg_ready), 32'd1);
  endtask

  initial begin
    rstn                = 1'b1;
    bus.cfg_valid       = 1'b0;
    bus.cfg_kernel_size = 8'd0;
    bus.w_valid         = 1'b0;
    bus.w_data          = 16'd0;
    bus.kernel_busy     = 4'b0;
    #1 rstn = 1'b0;
    #1;
    check("init_flush", 32'(bus.flush_kernel), 32'd0);
    check("init_valid", 32'(bus.fltr_valid), 32'd0);
    check("init_data", 32'(bus.fltr_data), 32'd0);
    check("init_ksize", 32'(bus.kernel_size), 32'd0);
    check("init_done", 32'(bus.load_done), 32'd0);
    check("init_err", 32'(bus.err_size), 32'd0);
    check("init_w_ready", 32'(bus.w_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("init_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("init_state", 32'(dbg_state), 32'd0);

    // Size 9, back-to-back weights, busy 0110 for five cycles.
    send_cfg(8'd9, 1'b0);
    load_body(9, 16'h0101, 32'd0, 0, 1'b0, 4'b0110, 5, 1'b0, 8'd0, -1);

    // Size 4 with bubbles 1,0,0,1,1,0,1 and a fifth word left on offer.
    send_cfg(8'd4, 1'b0);
    load_body(4, 16'hA000, 32'h59, 7, 1'b1, 4'b0001, 2, 1'b0, 8'd0, -1);

    // Illegal sizes, then a full-depth kernel.
    bad_cfg(8'd0);
    bad_cfg(8'd17);
    send_cfg(8'd16, 1'b0);
    load_body(16, 16'h1000, 32'd0, 0, 1'b0, 4'b1000, 3, 1'b0, 8'd0, -1);

    // Size 1, buffers already idle, config offered during the burst.
    send_cfg(8'd1, 1'b0);
    load_body(1, 16'h0777, 32'd0, 0, 1'b0, 4'b0000, 0, 1'b1, 8'd0, -1);

    // Reset in the middle of an 8-word burst, then a clean size-2 load.
    send_cfg(8'd8, 1'b0);
    load_body(8, 16'h8000, 32'd0, 0, 1'b0, 4'b0000, 0, 1'b0, 8'd0, 3);
    send_cfg(8'd2, 1'b0);
    load_body(2, 16'h2000, 32'd0, 0, 1'b0, 4'b0000, 0, 1'b0, 8'd0, -1);

    // cfg_valid held high: size 3, then size 5 accepted right at load_done.
    send_cfg(8'd3, 1'b1);
    load_body(3, 16'h3000, 32'd0, 0, 1'b0, 4'b0010, 2, 1'b0, 8'd5, -1);
    @(negedge clk);
    check("b2b_accept", 32'(bus.w_ready), 32'd1);
    check("b2b_ksize_old", 32'(bus.kernel_size), 32'd3);
    check("b2b_done_low", 32'(bus.load_done), 32'd0);
    bus.cfg_valid = 1'b0;
    load_body(5, 16'h5000, 32'd0, 0, 1'b0, 4'b0000, 1, 1'b0, 8'd0, -1);

    // Final report
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
